// File: rtl/div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// div_hilo_ctrl : HI/LO registers, MTHI/MTLO writes and multicycle divider
//                 handshake (start/annul/stall) for the EX stage.  Rev 1.0
// ============================================================================
module div_hilo_ctrl #(
  parameter int ABORT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid_i,
  input  logic [2:0]  ex_op_i,
  input  logic        ex_stall_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int              CNT_W    = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ABORT_CYCLES - 1);

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             start_q, start_d;
  logic             annul_q, annul_d;
  logic             signed_q, signed_d;
  logic [31:0]      op1_q, op1_d;
  logic [31:0]      op2_q, op2_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;

  logic div_req;
  logic mt_ok;

  assign div_req = ex_valid_i & ((ex_op_i == OP_DIV) | (ex_op_i == OP_DIVU)) & ~flush;
  assign mt_ok   = ex_valid_i & ~flush & ~ex_stall_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    annul_d  = annul_q;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    case (state_q)
      ST_IDLE: begin
        if (div_req) begin
          state_d  = ST_BUSY;
          start_d  = 1'b1;
          signed_d = (ex_op_i == OP_DIV);
          op1_d    = rs_data_i;
          op2_d    = rt_data_i;
        end else if (mt_ok) begin
          if (ex_op_i == OP_MTHI) hi_d = rs_data_i;
          if (ex_op_i == OP_MTLO) lo_d = rs_data_i;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_ABORT;
          start_d = 1'b0;
          annul_d = 1'b1;
          cnt_d   = '0;
        end else if (div_ready_i) begin
          state_d = ST_DONE;
          start_d = 1'b0;
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
          // A downstream stall keeps the divide itself in EX during DONE.
          held_d  = ex_stall_i;
        end
      end
      ST_DONE: begin
        if (flush) begin
          state_d = ST_ABORT;
          annul_d = 1'b1;
          cnt_d   = '0;
        end else if (!ex_stall_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          annul_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Stall is forced low while reset is held, independent of the inputs.
  always_comb begin
    stall_o = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE: stall_o = div_req;
        ST_BUSY: stall_o = ~div_ready_i;
        ST_DONE: stall_o = div_req & ~held_q;
        default: stall_o = div_req;
      endcase
    end
  end

  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_div_hilo_ctrl : directed and random transactions against a behavioural
//                    divide / HI-LO model.  Rev 1.0
// ============================================================================
module tb_div_hilo_ctrl;
  localparam int ABORT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, ex_valid, ex_stall, ready;
  logic [2:0]  ex_op;
  logic [31:0] rs, rt;
  logic [63:0] result;
  logic        div_start, div_annul, div_signed, stall;
  logic [31:0] op1, op2, hi, lo;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  div_hilo_ctrl #(.ABORT_CYCLES(ABORT_CYCLES)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid_i(ex_valid), .ex_op_i(ex_op), .ex_stall_i(ex_stall),
    .rs_data_i(rs), .rt_data_i(rt),
    .div_start_o(div_start), .div_annul_o(div_annul), .div_signed_o(div_signed),
    .div_op1_o(op1), .div_op2_o(op2),
    .div_result_i(result), .div_ready_i(ready),
    .stall_o(stall), .hi_o(hi), .lo_o(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_hilo(input string tag);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  // Abort window: optionally a fresh DIVU 9/3 is presented and must be held off.
  task automatic check_abort(input bit pre);
    flush = 0; ready = 0; ex_stall = 0;
    ex_valid = pre; ex_op = 3'd2; rs = 32'd9; rt = 32'd3;
    for (int i = 0; i < ABORT_CYCLES; i++) begin
      #1;
      chk("abort_annul", div_annul, 1);
      chk("abort_start", div_start, 0);
      chk("abort_stall", stall, pre);
      chk_hilo("abort");
      @(negedge clk);
    end
    #1;
    chk("post_abort_annul", div_annul, 0);
    chk("post_abort_start", div_start, 0);
    chk("post_abort_stall", stall, pre);
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] v, input bit stl, input bit fl);
    ex_valid = 1; ex_op = op; rs = v; ex_stall = stl; flush = fl;
    #1;
    chk("mt_stall", stall, 0);
    @(negedge clk);
    if (!stl && !fl) begin
      if (op == 3'd3) m_hi = v;
      else if (op == 3'd4) m_lo = v;
    end
    ex_valid = 0; ex_stall = 0; flush = 0;
    #1;
    chk_hilo("mt");
  endtask

  // One divide: lat = cycles in BUSY incl. ready cycle, hold = DONE stall cycles,
  // fl = cycle index of a flush (0 none), pre = present DIVU 9/3 right after.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int hold, input int fl, input bit pre);
    logic [63:0] res;
    longint      sa, sb;
    if (b == 32'd0) begin
      res = {$urandom, $urandom};
    end else begin
      sa  = sgn ? longint'($signed(a)) : longint'(a);
      sb  = sgn ? longint'($signed(b)) : longint'(b);
      res = {32'(sa % sb), 32'(sa / sb)};
    end
    ex_valid = 1; ex_op = sgn ? 3'd1 : 3'd2; rs = a; rt = b;
    ex_stall = 0; flush = 0; ready = 0;
    #1;
    chk("req_stall", stall, 1);
    chk("req_start", div_start, 0);
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      ready    = (k == lat);
      result   = ready ? res : {$urandom, $urandom};
      ex_stall = (k == lat) && (hold > 0);
      flush    = (fl == k);
      #1;
      chk("busy_start", div_start, 1);
      chk("busy_signed", div_signed, sgn);
      chk("busy_op1", op1, a);
      chk("busy_op2", op2, b);
      chk("busy_stall", stall, !ready);
      chk("busy_annul", div_annul, 0);
      @(negedge clk);
      if (fl == k) begin
        check_abort(pre);
        return;
      end
    end
    ready = 0;
    m_hi  = res[63:32];
    m_lo  = res[31:0];
    if (hold == 0) ex_valid = 0;
    for (int h = 0; h <= hold; h++) begin
      ex_stall = (h < hold);
      flush    = (fl == lat + 1 + h);
      if (hold == 0 && pre) begin
        ex_valid = 1; ex_op = 3'd2; rs = 32'd9; rt = 32'd3;
      end
      #1;
      chk("done_start", div_start, 0);
      chk("done_stall", stall, (hold == 0) && pre && !flush);
      chk_hilo("done");
      @(negedge clk);
      if (fl == lat + 1 + h) begin
        check_abort(pre);
        return;
      end
    end
    if (!(hold == 0 && pre)) ex_valid = 0;
    ex_stall = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 0; flush = 0; ex_valid = 0; ex_stall = 0; ex_op = 0;
    rs = 0; rt = 0; ready = 0; result = 0; m_hi = 0; m_lo = 0;
    @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_start", div_start, 0);
    chk("rst_annul", div_annul, 0);
    chk("rst_signed", div_signed, 0);
    chk("rst_op1", op1, 0);
    chk("rst_op2", op2, 0);
    chk_hilo("rst");
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    do_mt(3'd3, 32'h1234_5678, 0, 0);
    do_mt(3'd4, 32'h9ABC_DEF0, 0, 0);
    do_div(0, 32'd100, 32'd7, 5, 0, 0, 0);
    chk("divu_100_7_lo", lo, 32'd14);
    chk("divu_100_7_hi", hi, 32'd2);
    do_div(1, 32'hFFFF_FFF9, 32'd2, 4, 0, 0, 0);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    do_div(1, 32'd1000, 32'd33, 3, 5, 0, 0);
    do_div(0, 32'd1234, 32'd5, 20, 0, 10, 1);
    do_div(0, 32'd9, 32'd3, 2, 0, 0, 0);
    chk("divu_9_3_lo", lo, 32'd3);
    chk("divu_9_3_hi", hi, 32'd0);
    do_div(1, 32'd77, 32'd7, 4, 0, 4, 0);
    do_div(0, 32'd50, 32'd6, 2, 2, 4, 0);
    do_div(0, 32'd81, 32'd9, 3, 0, 0, 1);
    do_div(0, 32'd9, 32'd3, 3, 0, 0, 0);
    do_div(1, 32'd5, 32'd0, 3, 0, 0, 0);
    do_mt(3'd3, 32'hDEAD_BEEF, 1, 0);
    do_mt(3'd4, 32'hCAFE_F00D, 0, 1);
    do_mt(3'd6, 32'h0BAD_0BAD, 0, 0);

    // Reset in the middle of a divide
    ex_valid = 1; ex_op = 3'd2; rs = 32'd50; rt = 32'd5; ready = 0;
    #1;
    @(negedge clk);
    #1;
    chk("pre_rst_start", div_start, 1);
    @(negedge clk);
    rst = 0;
    #1;
    m_hi = 0; m_lo = 0;
    chk("midrst_start", div_start, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_signed", div_signed, 0);
    chk("midrst_op1", op1, 0);
    chk("midrst_op2", op2, 0);
    chk("midrst_annul", div_annul, 0);
    chk_hilo("midrst");
    ex_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    do_div(0, 32'd100, 32'd7, 5, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      int          kind, lat, hold, fl, sel;
      logic [31:0] a, b;
      logic [2:0]  op;
      kind = $urandom_range(0, 9);
      if (kind <= 2) begin
        sel = $urandom_range(0, 3);
        op  = (kind == 0) ? 3'd3 : (kind == 1) ? 3'd4 : ((sel == 0) ? 3'd0 : 3'(sel + 4));
        do_mt(op, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      end else begin
        a    = $urandom;
        sel  = $urandom_range(0, 5);
        b    = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
        lat  = $urandom_range(1, 12);
        hold = $urandom_range(0, 3);
        fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat + 1 + hold) : 0;
        do_div(1'($urandom_range(0, 1)), a, b, lat, hold, fl, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_hilo_ctrl.md
DIV_HILO_CTRL -- requirements
Module: div_hilo_ctrl

Interface
REQ-001 The block SHALL have parameter ABORT_CYCLES, default 2: number of cycles of divider drain after a flush.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-004 The block SHALL have port flush  input  1  pipeline flush; kills the EX-stage instruction and any divide in flight.
REQ-005 The block SHALL have port ex_valid_i  input  1  EX-stage instruction valid.
REQ-006 The block SHALL have port ex_op_i  input  3  operation: 0 none, 1 DIV, 2 DIVU, 3 MTHI, 4 MTLO; others treated as none.
REQ-007 The block SHALL have port ex_stall_i  input  1  downstream stall; holds the EX instruction in place.
REQ-008 The block SHALL have port rs_data_i  input  32  dividend, or MTHI/MTLO source.
REQ-009 The block SHALL have port rt_data_i  input  32  divisor.
REQ-010 The block SHALL have port div_start_o  output  1  divider start; 1 = start, 0 = stop.
REQ-011 The block SHALL have port div_annul_o  output  1  divider annul.
REQ-012 The block SHALL have port div_signed_o  output  1  1 for DIV, 0 for DIVU.
REQ-013 The block SHALL have port div_op1_o  output  32  latched dividend.
REQ-014 The block SHALL have port div_op2_o  output  32  latched divisor.
REQ-015 The block SHALL have port div_result_i  input  64  {remainder[63:32], quotient[31:0]} from the divider.
REQ-016 The block SHALL have port div_ready_i  input  1  divider result valid.
REQ-017 The block SHALL have port stall_o  output  1  pipeline stall request (combinational).
REQ-018 The block SHALL have port hi_o  output  32  HI register.
REQ-019 The block SHALL have port lo_o  output  32  LO register.

Function
REQ-020 The block SHALL implement states IDLE, BUSY, DONE and ABORT.
REQ-021 The block SHALL define div_req = ex_valid_i & (ex_op_i==1 | ex_op_i==2) & !flush.
REQ-022 In IDLE with div_req, the block SHALL latch rs/rt into op1/op2, set div_signed_o = (ex_op_i==1), set div_start_o=1 at the edge, enter BUSY, and drive stall_o=1 in the request cycle.
REQ-023 In BUSY, div_start_o, div_signed_o, op1 and op2 SHALL remain constant, and stall_o SHALL equal !div_ready_i.
REQ-024 In BUSY with div_ready_i=1 and no flush, the block SHALL load hi <= div_result_i[63:32] and lo <= div_result_i[31:0], clear div_start_o, and enter DONE.
REQ-025 In DONE, the block SHALL hold div_start_o=0 and stall_o=0, never re-issue the held instruction, and go to IDLE when ex_stall_i=0; while ex_stall_i=1 it SHALL remain in DONE.
REQ-026 In DONE or ABORT, a div_req from a newly presented instruction SHALL assert stall_o; it SHALL be accepted in IDLE on a later cycle.
REQ-027 On flush in BUSY or DONE, the block SHALL clear div_start_o, assert div_annul_o, and enter ABORT; HI/LO SHALL NOT be written, including when div_ready_i=1 in the same cycle.
REQ-028 In ABORT, the block SHALL keep div_annul_o=1 and div_start_o=0 for ABORT_CYCLES cycles, then enter IDLE with div_annul_o=0.
REQ-029 A zero divisor SHALL be issued normally; HI/LO SHALL take whatever div_result_i returns, and no exception SHALL be raised.
REQ-030 MTHI/MTLO SHALL write hi/lo from rs_data_i when ex_valid_i & !flush & !ex_stall_i & state==IDLE, with no stall.
REQ-031 Outside REQ-024 and REQ-030, hi_o and lo_o SHALL hold their values.
REQ-032 In IDLE, stall_o SHALL be 0 for all non-divide operations.

Reset
REQ-033 While rst=0, the block SHALL force state=IDLE, div_start_o=0, div_annul_o=0, div_signed_o=0, op1=op2=0, hi=lo=0 and stall_o=0 asynchronously.
REQ-034 Reset asserted mid-divide SHALL abandon the operation without any HI/LO write; the divider's own reset SHALL handle its own state.

Verification
REQ-035 DIVU 100/7 -> stall_o high until div_ready_i, then lo=14, hi=2, and start falls the next cycle.
REQ-036 DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, and div_signed_o=1 throughout BUSY.
REQ-037 DIV with ex_stall_i held 5 cycles after div_ready_i -> exactly one start pulse, HI/LO written once, and DONE held 5 cycles.
REQ-038 flush 10 cycles into BUSY -> annul=1 for 2 cycles, start=0, HI/LO unchanged, and a following DIVU 9/3 gives lo=3, hi=0.
REQ-039 MTHI 0x12345678 then MTLO 0x9ABCDEF0 with no stall -> hi_o=0x12345678 and lo_o=0x9ABCDEF0 one cycle after each.
REQ-040 rst pulsed low during BUSY -> all outputs 0 immediately, then normal operation after release.
